// File: rtl/rdcla_sub_pipe.sv
// rtl/rdcla_sub_pipe.sv - pipelined recursive-doubling carry-lookahead subtractor
//
// Computes d = a - b - bin as a + ~b + ~bin through a kill/generate/propagate
// prefix network, one register stage per doubling level, valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   a, b, bin valid this cycle
//   in_ready   block accepts an operand set this cycle (combinational from out_ready)
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result fields valid
//   out_ready  downstream accepts the result this cycle
//   d          difference modulo 2^WIDTH
//   bout       unsigned borrow out (a < b + bin)
//   zero       d == 0
//   ovf        signed overflow of the subtraction

module rdcla_sub_pipe #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int LEVELS = $clog2(WIDTH);

   // Prefix arrays: index n holds bit position n-1, so index 0 is the
   // carry-in pseudo-bit (generate when bin=0, kill when bin=1).
   // Encoding: g=1 generate, p=1 propagate, both 0 kill.
   logic [LEVELS:0][WIDTH:0]   g_q, g_d, p_q, p_d;
   logic [LEVELS:0][WIDTH-1:0] pr_q, pr_d;   // per-bit propagate, kept for the sum
   logic [LEVELS:0]            sa_q, sa_d, sb_q, sb_d, v_q, v_d;

   // Final stage: resolved difference and carry out.
   logic [WIDTH-1:0] fd_q, fd_d;
   logic             fc_q, fc_d, fsa_q, fsa_d, fsb_q, fsb_d, fv_q, fv_d;

   // Output registers.
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;

   logic adv;

   always_comb begin
      adv = !out_valid_q || out_ready;

      // Stage 0: per-bit kgp of a + ~b.
      g_d[0][0]       = ~bin;
      p_d[0][0]       = 1'b0;
      g_d[0][WIDTH:1] = a & ~b;
      p_d[0][WIDTH:1] = ~(a ^ b);
      pr_d[0]         = ~(a ^ b);
      sa_d[0]         = a[WIDTH-1];
      sb_d[0]         = b[WIDTH-1];
      v_d[0]          = in_valid;

      // Doubling levels: combine with the entry 2^(j-1) below; entries with
      // nothing below in range pass through.
      for (int j = 1; j <= LEVELS; j++) begin
         g_d[j]  = g_q[j-1];
         p_d[j]  = p_q[j-1];
         for (int n = (1 << (j-1)); n <= WIDTH; n++) begin
            g_d[j][n] = g_q[j-1][n] | (p_q[j-1][n] & g_q[j-1][n - (1 << (j-1))]);
            p_d[j][n] = p_q[j-1][n] & p_q[j-1][n - (1 << (j-1))];
         end
         pr_d[j] = pr_q[j-1];
         sa_d[j] = sa_q[j-1];
         sb_d[j] = sb_q[j-1];
         v_d[j]  = v_q[j-1];
      end

      // Carry into bit i is the resolved prefix at index i. The top entry
      // spans bits 0..WIDTH-1 only, so the carry-in is folded in here.
      fd_d  = pr_q[LEVELS] ^ g_q[LEVELS][WIDTH-1:0];
      fc_d  = g_q[LEVELS][WIDTH] | (p_q[LEVELS][WIDTH] & g_q[LEVELS][0]);
      fsa_d = sa_q[LEVELS];
      fsb_d = sb_q[LEVELS];
      fv_d  = v_q[LEVELS];

      // Output data only changes when a real result arrives, so bubbles
      // leave the last (or reset) values in place.
      out_valid_d = fv_q;
      d_d         = d_q;
      bout_d      = bout_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      if (fv_q) begin
         d_d    = fd_q;
         bout_d = ~fc_q;
         zero_d = (fd_q == '0);
         ovf_d  = (fsa_q != fsb_q) && (fd_q[WIDTH-1] != fsa_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         g_q         <= '0;
         p_q         <= '0;
         pr_q        <= '0;
         sa_q        <= '0;
         sb_q        <= '0;
         v_q         <= '0;
         fd_q        <= '0;
         fc_q        <= 1'b0;
         fsa_q       <= 1'b0;
         fsb_q       <= 1'b0;
         fv_q        <= 1'b0;
         d_q         <= '0;
         bout_q      <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (adv) begin
         g_q         <= g_d;
         p_q         <= p_d;
         pr_q        <= pr_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         v_q         <= v_d;
         fd_q        <= fd_d;
         fc_q        <= fc_d;
         fsa_q       <= fsa_d;
         fsb_q       <= fsb_d;
         fv_q        <= fv_d;
         d_q         <= d_d;
         bout_q      <= bout_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign bout      = bout_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_rdcla_sub_pipe.sv
// tb/tb_rdcla_sub_pipe.sv - self-checking bench for rdcla_sub_pipe

module tb_rdcla_sub_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] d;
   logic        bout, zero, ovf;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] d;
      logic        bout;
      logic        zero;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   pop_cyc[$];
   int   pop_lat[$];
   exp_t me;

   rdcla_sub_pipe #(.WIDTH(64)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .bout(bout), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every consumed result is popped from the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else if (out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output d=%h bout=%b zero=%b ovf=%b", d, bout, zero, ovf);
         end else begin
            me = sb.pop_front();
            if ({d, bout, zero, ovf} !== {me.d, me.bout, me.zero, me.ovf}) begin
               failures++;
               $display("FAIL result got d=%h bout=%b zero=%b ovf=%b want d=%h bout=%b zero=%b ovf=%b",
                        d, bout, zero, ovf, me.d, me.bout, me.zero, me.ovf);
            end
            pop_cyc.push_back(cyc);
            pop_lat.push_back(cyc - me.acc);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [63:0] ta, input logic [63:0] tb2, input logic tbin);
      exp_t        e;
      logic [64:0] full;
      full   = {1'b0, ta} - {1'b0, tb2} - 65'(tbin);
      e.d    = full[63:0];
      e.bout = full[64];
      e.zero = (full[63:0] == 64'd0);
      e.ovf  = (ta[63] != tb2[63]) && (full[63] != ta[63]);
      e.acc  = 0;
      a = ta; b = tb2; bin = tbin; in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            e.acc = cyc + 1;
            sb.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 300; t++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, d, bout, zero, ovf} !== 68'd0) begin
         failures++;
         $display("FAIL reset_outputs got v=%b d=%h bout=%b zero=%b ovf=%b want all 0",
                  out_valid, d, bout, zero, ovf);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int base;
      base = pop_lat.size();
      send(64'd250, 64'd123, 1'b0);
      drain();
      checks++;
      if (pop_lat.size() != base + 1 || pop_lat[base] != 8) begin
         failures++;
         $display("FAIL basic_latency got %0d want 8", (pop_lat.size() > base) ? pop_lat[base] : -1);
      end
   endtask

   task automatic test_underflow();
      send(64'd123, 64'd127, 1'b0);
      send(64'd5, 64'd5, 1'b1);
      send(64'd0, 64'd0, 1'b1);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
      drain();
   endtask

   task automatic test_flags();
      send(64'h8000_0000_0000_0000, 64'd1, 1'b0);
      send(64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0);
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      drain();
   endtask

   task automatic test_back_to_back();
      int base;
      base = pop_cyc.size();
      for (int i = 0; i < 20; i++)
         send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1, 0)));
      drain();
      checks++;
      if (pop_cyc.size() - base != 20) begin
         failures++;
         $display("FAIL stream_count got %0d want 20", pop_cyc.size() - base);
      end else begin
         checks++;
         if (pop_lat[base] != 8) begin
            failures++;
            $display("FAIL stream_first_latency got %0d want 8", pop_lat[base]);
         end
         checks++;
         if (pop_cyc[base+19] - pop_cyc[base] != 19) begin
            failures++;
            $display("FAIL stream_consecutive span got %0d want 19", pop_cyc[base+19] - pop_cyc[base]);
         end
      end
   endtask

   task automatic test_backpressure();
      int          base;
      logic [67:0] held;
      base = pop_cyc.size();
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 10; i++)
               send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1, 0)));
         end
         begin
            for (int t = 0; t < 100; t++) begin
               @(negedge clk);
               if (out_valid) break;
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (k == 0) held = {out_valid, d, bout, zero, ovf};
               checks++;
               if (in_ready !== 1'b0) begin
                  failures++;
                  $display("FAIL stall_in_ready got %b want 0", in_ready);
               end
               checks++;
               if ({out_valid, d, bout, zero, ovf} !== held || out_valid !== 1'b1) begin
                  failures++;
                  $display("FAIL stall_hold got v=%b d=%h want v=%b d=%h",
                           out_valid, d, held[67], held[66:3]);
               end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();
      checks++;
      if (pop_cyc.size() - base != 10) begin
         failures++;
         $display("FAIL backpressure_count got %0d want 10", pop_cyc.size() - base);
      end
   endtask

   task automatic test_reset_midflight();
      int base;
      base = pop_lat.size();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         send(64'd1000 + 64'(i), 64'd7, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_in_ready got %b want 1", in_ready);
      end
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, d, bout, zero, ovf} !== 68'd0) begin
            failures++;
            $display("FAIL midreset_outputs got v=%b d=%h bout=%b zero=%b ovf=%b want all 0",
                     out_valid, d, bout, zero, ovf);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (pop_lat.size() != base) begin
         failures++;
         $display("FAIL midreset_leak got %0d results want 0", pop_lat.size() - base);
      end
      send(64'd42, 64'd40, 1'b1);
      drain();
      checks++;
      if (pop_lat.size() != base + 1 || pop_lat[base] != 8) begin
         failures++;
         $display("FAIL midreset_new_latency got %0d want 8", (pop_lat.size() > base) ? pop_lat[base] : -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_flags();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rdcla_sub_pipe.md
Name: rdcla_sub_pipe

Overview:
Pipelined 64-bit subtractor, the inverse operation of the team's recursive-doubling carry-lookahead adder. It computes d = a - b - bin as a + ~b + ~bin, using the same kill/generate/propagate recursive-doubling prefix network. One register stage sits between each doubling level. A valid/ready handshake gives a throughput of one operation per cycle, with backpressure. The block sits beside the adder in the datapath and feeds downstream compare/branch logic with borrow, zero and signed-overflow flags.

Parameters:
WIDTH, 64, operand width in bits; must be a power of two, minimum 2.
LEVELS, log2(WIDTH) (6 at default), derived localparam: number of doubling levels. Not overridable.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  a, b and bin are valid this cycle.
in_ready  output  1  block accepts an operand set this cycle.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
bin  input  1  borrow in.
out_valid  output  1  result fields are valid.
out_ready  input  1  downstream accepts the result this cycle.
d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
bout  output  1  unsigned borrow out; 1 when a < b + bin.
zero  output  1  d == 0.
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).

Behaviour:
- Reset: one clk edge with reset=1 clears every stage valid bit, out_valid, d, bout, zero and ovf to 0. Reset has priority over everything.
- Reset mid-operation: all in-flight operations are discarded and never appear at the output. in_ready reads 1 in the first cycle after reset deasserts.
- Advance condition: adv = !out_valid || out_ready.
  - in_ready = adv, combinational.
  - The whole pipeline shifts only when adv=1. Otherwise every stage, including the outputs, holds its value.
- Accept: an operand set is captured when in_valid && in_ready. A bubble (valid=0) enters when in_valid=0 and adv=1.
- Stage 0 (input register):
  - Per bit i: k_i = ~a_i & b_i, g_i = a_i & ~b_i, p_i = ~(a_i ^ b_i).
  - Carry-in c0 = ~bin, folded in as bit -1 (generate if bin=0, kill if bin=1).
  - Registered together with the a[MSB] and b[MSB] signs.
- Stages 1..LEVELS:
  - Level j combines the kgp of position i with position i - 2^(j-1) using the standard composition (k or g dominates, p passes through).
  - Positions with i - 2^(j-1) < -1 pass through unchanged.
  - Each level is registered, with its own valid bit.
- Final stage:
  - d_i = p_i ^ c_i, where c_i = 1 iff the resolved prefix at position i-1 is g.
  - cout = 1 iff the resolved prefix at position WIDTH-1 is g; bout = ~cout.
  - zero and ovf are computed from d; all are registered into the outputs.
- Latency: LEVELS+2 cycles (8 at default) from the accept edge to out_valid=1, provided no stall occurs.
- Throughput: 1 operation per cycle while out_ready=1.
- Output hold: while out_valid=1 && out_ready=0, the values of d, bout, zero and ovf are stable. The result is consumed on the edge where out_valid && out_ready.
- Ordering: results leave in acceptance order. There is no drop and no duplication.
- Boundaries:
  - a=b with bin=0 gives zero=1, bout=0.
  - a=b with bin=1 gives d all-ones, bout=1.
  - Width wraps modulo 2^WIDTH.
- No combinational path from a, b or bin to any output. The only combinational path is out_ready -> in_ready.

Test Plan:
1. Basic subtract: a=250, b=123, bin=0, one op -> after 8 cycles, out_valid=1, d=127, bout=0, zero=0, ovf=0.
2. Unsigned underflow: a=123, b=127, bin=0 -> d=18446744073709551612 (0xFFFF_FFFF_FFFF_FFFC), bout=1, ovf=0. With bin=1 on a=5, b=5 -> d=0xFFFF_FFFF_FFFF_FFFF, bout=1, zero=0.
3. Flags: a=0x8000_0000_0000_0000, b=1 -> d=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0. Separately, a=b=0xDEAD_BEEF, bin=0 -> zero=1.
4. Streaming: 20 back-to-back ops with random a/b/bin and out_ready=1 -> 20 results on consecutive cycles, first result 8 cycles after the first accept, all matching the reference model a-b-bin, in order.
5. Backpressure: stream 10 ops and drop out_ready for 3 cycles while out_valid=1 -> in_ready=0 during the stall, outputs held stable, no loss or duplication, all 10 results correct after release.
6. Reset mid-flight: accept 4 ops, assert reset for 1 cycle on cycle 3 -> out_valid=0 and all outputs 0 afterwards, none of the 4 results ever appear, and a new op accepted after reset returns its result 8 cycles later.
